ps2_kbd_ctrl: RTL and testbench
===============================

Name: ps2_kbd_ctrl

Overview:
- Sits between the PS/2 frame receiver and the CPU-side MMIO keyboard register.
- Consumes validated scan-code bytes and decodes the set-2 prefix sequences (E0 extended, F0 break) into complete key events.
- Tracks shift state and suppresses typematic repeats.
- Queues events in a first-word-fall-through FIFO that the bus side drains with a read strobe.

Parameters:
FIFO_DEPTH, 8, number of event entries; power of two, at least 2
ADDR_W, 3, log2(FIFO_DEPTH)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
scan_valid  in  1  one-cycle strobe: scan_code holds a received byte
scan_code  in  8  received set-2 byte
rd_en  in  1  pop head event; ignored when evt_valid=0
clr_ovf  in  1  clears the overflow flag
evt_valid  out  1  FIFO non-empty
evt_data  out  16  head event: [15]=break, [14]=extended, [13]=shift, [12:8]=0, [7:0]=code
fifo_count  out  ADDR_W+1  entries held, 0..FIFO_DEPTH
overflow  out  1  sticky: an event was dropped because the FIFO was full
shift_held  out  1  left or right shift currently pressed

Behaviour:
- Reset (synchronous, active-high): FSM=IDLE, FIFO empty, pointers=0.
  - evt_valid=0, evt_data=0, fifo_count=0, overflow=0, shift_held=0.
  - Repeat register cleared. Reset mid-sequence discards any partial prefix.
- The FSM advances only on cycles with scan_valid=1. States are IDLE, EXT, BRK, EXT_BRK.
  - IDLE: E0 -> EXT; F0 -> BRK; 00/FF (error codes) -> discard, stay IDLE; other bytes -> emit make, ext=0.
  - EXT: F0 -> EXT_BRK; E0 -> stay EXT; 00/FF -> IDLE, no event; other bytes -> emit make, ext=1, -> IDLE.
  - BRK: F0 -> stay BRK; E0 -> EXT (the break is abandoned); 00/FF -> IDLE; other bytes -> emit break, ext=0, -> IDLE.
  - EXT_BRK: F0 -> stay; E0 -> EXT; 00/FF -> IDLE; other bytes -> emit break, ext=1, -> IDLE.
- Shift tracking:
  - lshift = non-extended code 12; rshift = non-extended code 59. Each is set on make and cleared on break.
  - shift_held = lshift | rshift.
  - The event's shift bit is the value after applying that event, so a shift make carries shift=1 and a shift break carries shift=0 when the other shift is up.
- Repeat suppression:
  - A {ext, code} register holds the last make that was emitted.
  - A make equal to it is dropped and not queued.
  - A break of that key clears the register. Any different make overwrites it.
  - Shift and repeat state update on every decoded event, even if the FIFO is full.
- FIFO:
  - A push occurs on the scan_valid cycle that completes an event.
  - Registered storage: evt_valid/evt_data/fifo_count reflect the push from the next cycle (1-cycle latency).
  - A pop happens on rd_en & evt_valid; the next head appears the cycle after.
  - Push and pop in the same cycle: both happen, fifo_count unchanged. This holds when full, so no drop occurs.
  - Push when full without a pop: the event is dropped, overflow<=1, and the FIFO contents are unchanged.
  - Pointers wrap modulo FIFO_DEPTH. fifo_count never exceeds FIFO_DEPTH.
  - overflow is sticky. clr_ovf clears it. If clr_ovf and a new drop occur in the same cycle, the drop wins and overflow=1.
- evt_data while empty is don't-care; the bench must only check it when evt_valid=1.

Test Plan:
- Bytes 1C; F0,1C; E0,75; E0,F0,75 -> four events: 001C, 801C, 4075, C075; fifo_count=4.
- Bytes 12, 1C, F0,1C, F0,12 -> events 2012, 201C, A01C, 8012; shift_held goes 1 then 0.
- Bytes 1C,1C,1C,F0,1C,1C -> only 001C, 801C, 001C queued (the two repeats are dropped).
- Push 9 distinct makes with FIFO_DEPTH=8 and no reads:
  - fifo_count=8, overflow=1, and the head is still the first event.
  - Pulse clr_ovf -> overflow=0.
  - With the FIFO full, do a push and rd_en in the same cycle -> count stays 8 and overflow stays 0.
- Bytes E0, then reset asserted for 1 cycle, then 1C -> event 001C (ext=0); all outputs are 0 during reset.
- Bytes F0,E0,6B and 00,1C -> events 406B and 001C; the error byte produces no event.

Source files
------------

// File: rtl/ps2_kbd_ctrl.sv
// rtl/ps2_kbd_ctrl.sv - PS/2 set-2 scan-code decoder with shift tracking, repeat suppression and event FIFO
module ps2_kbd_ctrl #(
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              scan_valid,
    input  logic [7:0]        scan_code,
    input  logic              rd_en,
    input  logic              clr_ovf,
    output logic              evt_valid,
    output logic [15:0]       evt_data,
    output logic [ADDR_W:0]   fifo_count,
    output logic              overflow,
    output logic              shift_held
);
    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(FIFO_DEPTH);

    state_t              state;
    logic                lshift, rshift;
    logic                rep_valid;
    logic [8:0]          rep_key;
    logic [15:0]         mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
    logic [ADDR_W:0]     count;
    logic                ovf_q;

    logic        is_e0, is_f0, is_err, emit, ev_ext, ev_brk;
    logic        lshift_nxt, rshift_nxt, is_repeat, push, pop, full, do_push, drop;
    logic [8:0]  key;
    logic [15:0] ev_word;

    assign is_e0   = (scan_code == 8'hE0);
    assign is_f0   = (scan_code == 8'hF0);
    assign is_err  = (scan_code == 8'h00) || (scan_code == 8'hFF);
    assign ev_ext  = (state == EXT) || (state == EXT_BRK);
    assign ev_brk  = (state == BRK) || (state == EXT_BRK);
    assign emit    = scan_valid & ~is_e0 & ~is_f0 & ~is_err;
    assign key     = {ev_ext, scan_code};

    // Event shift bit reflects the shift state after this event is applied
    assign lshift_nxt = (emit && key == 9'h012) ? ~ev_brk : lshift;
    assign rshift_nxt = (emit && key == 9'h059) ? ~ev_brk : rshift;
    assign ev_word    = {ev_brk, ev_ext, lshift_nxt | rshift_nxt, 5'd0, scan_code};

    assign is_repeat = ~ev_brk & rep_valid & (rep_key == key);
    assign push      = emit & ~is_repeat;
    assign full      = (count == DEPTH_C);
    assign pop       = rd_en & (count != '0);
    assign do_push   = push & (~full | pop);
    assign drop      = push & full & ~pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            lshift    <= 1'b0;
            rshift    <= 1'b0;
            rep_valid <= 1'b0;
            rep_key   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            if (scan_valid) begin
                case (state)
                    IDLE:    state <= is_e0 ? EXT : (is_f0 ? BRK : IDLE);
                    EXT:     state <= is_e0 ? EXT : (is_f0 ? EXT_BRK : IDLE);
                    BRK:     state <= is_e0 ? EXT : (is_f0 ? BRK : IDLE);
                    EXT_BRK: state <= is_e0 ? EXT : (is_f0 ? EXT_BRK : IDLE);
                    default: state <= IDLE;
                endcase
            end
            lshift <= lshift_nxt;
            rshift <= rshift_nxt;
            if (emit) begin
                if (ev_brk) begin
                    if (rep_valid && rep_key == key)
                        rep_valid <= 1'b0;
                end else if (!is_repeat) begin
                    rep_key   <= key;
                    rep_valid <= 1'b1;
                end
            end
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop)
                ovf_q <= 1'b1;
            else if (clr_ovf)
                ovf_q <= 1'b0;
        end
    end

    // When full, a simultaneous pop frees the slot being overwritten
    always_ff @(posedge clk) begin
        if (!reset && do_push)
            mem[wr_ptr] <= ev_word;
    end

    assign evt_valid  = (count != '0);
    assign evt_data   = evt_valid ? mem[rd_ptr] : 16'h0000;
    assign fifo_count = count;
    assign overflow   = ovf_q;
    assign shift_held = lshift | rshift;
endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// tb/tb_ps2_kbd_ctrl.sv - directed and randomized bench for ps2_kbd_ctrl with a prefix-flag reference model
module tb_ps2_kbd_ctrl;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        scan_valid = 1'b0;
    logic [7:0]  scan_code = 8'h00;
    logic        rd_en = 1'b0;
    logic        clr_ovf = 1'b0;
    logic        evt_valid;
    logic [15:0] evt_data;
    logic [3:0]  fifo_count;
    logic        overflow;
    logic        shift_held;

    int n_checks = 0;
    int n_fail = 0;

    ps2_kbd_ctrl #(.FIFO_DEPTH(DEPTH), .ADDR_W(3)) dut (
        .clk(clk), .reset(reset), .scan_valid(scan_valid), .scan_code(scan_code),
        .rd_en(rd_en), .clr_ovf(clr_ovf), .evt_valid(evt_valid), .evt_data(evt_data),
        .fifo_count(fifo_count), .overflow(overflow), .shift_held(shift_held)
    );

    always #5 clk = ~clk;

    // Reference model: pending-prefix flags, key-state booleans and a queue
    bit          m_ext, m_brk, m_l, m_r, m_rep_v, m_ovf;
    bit [8:0]    m_rep;
    logic [15:0] m_q[$];
    logic [15:0] got[$];

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_l = 0; m_r = 0; m_rep_v = 0; m_ovf = 0; m_rep = 0;
        m_q.delete();
    endtask

    task automatic model_step(input bit v, input logic [7:0] c, input bit rd, input bit clr);
        bit push = 0;
        bit drop = 0;
        logic [15:0] ev = 0;
        bit [8:0] k;
        if (v) begin
            if (c == 8'hE0) begin
                m_ext = 1; m_brk = 0;
            end else if (c == 8'hF0) begin
                m_brk = 1;
            end else if (c == 8'h00 || c == 8'hFF) begin
                m_ext = 0; m_brk = 0;
            end else begin
                k = {m_ext, c};
                if (k == 9'h012) m_l = !m_brk;
                if (k == 9'h059) m_r = !m_brk;
                ev = {m_brk, m_ext, m_l | m_r, 5'd0, c};
                if (m_brk) begin
                    if (m_rep_v && m_rep == k) m_rep_v = 0;
                    push = 1;
                end else if (!(m_rep_v && m_rep == k)) begin
                    m_rep = k; m_rep_v = 1; push = 1;
                end
                m_ext = 0; m_brk = 0;
            end
        end
        if (rd && m_q.size() > 0) void'(m_q.pop_front());
        if (push) begin
            if (m_q.size() < DEPTH) m_q.push_back(ev);
            else drop = 1;
        end
        if (drop) m_ovf = 1;
        else if (clr) m_ovf = 0;
    endtask

    task automatic tick(input bit v, input logic [7:0] c, input bit rd, input bit clr);
        scan_valid = v; scan_code = c; rd_en = rd; clr_ovf = clr;
        @(posedge clk);
        if (reset) model_reset();
        else model_step(v, c, rd, clr);
        #1;
        scan_valid = 0; rd_en = 0; clr_ovf = 0;
    endtask

    task automatic send(input logic [7:0] c);
        tick(1, c, 0, 0);
    endtask

    task automatic do_reset();
        reset = 1;
        tick(0, 8'h00, 0, 0);
        reset = 0;
    endtask

    task automatic drain();
        got.delete();
        for (int i = 0; i < 2 * DEPTH && evt_valid; i++) begin
            got.push_back(evt_data);
            tick(0, 8'h00, 1, 0);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({evt_valid, evt_data, fifo_count, overflow, shift_held} !== 23'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b d=%h c=%0d o=%b s=%b want all 0",
                     evt_valid, evt_data, fifo_count, overflow, shift_held);
        end
    endtask

    task automatic test_prefixes();
        logic [15:0] exp[4] = '{16'h001C, 16'h801C, 16'h4075, 16'hC075};
        logic [7:0]  b[7] = '{8'h1C, 8'hF0, 8'h1C, 8'hE0, 8'h75, 8'hE0, 8'hF0};
        do_reset();
        foreach (b[i]) send(b[i]);
        send(8'h75);
        n_checks++;
        if (fifo_count !== 4'd4) begin
            n_fail++; $display("FAIL prefix_count: got %0d want 4", fifo_count);
        end
        drain();
        n_checks++;
        if (got.size() != 4) begin
            n_fail++; $display("FAIL prefix_events: got %0d events want 4", got.size());
        end else foreach (exp[i]) begin
            n_checks++;
            if (got[i] !== exp[i]) begin
                n_fail++; $display("FAIL prefix_event%0d: got %h want %h", i, got[i], exp[i]);
            end
        end
    endtask

    task automatic test_shift();
        logic [15:0] exp[4] = '{16'h2012, 16'h201C, 16'hA01C, 16'h8012};
        do_reset();
        send(8'h12);
        n_checks++;
        if (shift_held !== 1'b1) begin
            n_fail++; $display("FAIL shift_held_set: got %b want 1", shift_held);
        end
        send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
        n_checks++;
        if (shift_held !== 1'b0) begin
            n_fail++; $display("FAIL shift_held_clr: got %b want 0", shift_held);
        end
        drain();
        n_checks++;
        if (got.size() != 4) begin
            n_fail++; $display("FAIL shift_events: got %0d events want 4", got.size());
        end else foreach (exp[i]) begin
            n_checks++;
            if (got[i] !== exp[i]) begin
                n_fail++; $display("FAIL shift_event%0d: got %h want %h", i, got[i], exp[i]);
            end
        end
    endtask

    task automatic test_repeat();
        logic [15:0] exp[3] = '{16'h001C, 16'h801C, 16'h001C};
        logic [7:0]  b[6] = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C};
        do_reset();
        foreach (b[i]) send(b[i]);
        drain();
        n_checks++;
        if (got.size() != 3) begin
            n_fail++; $display("FAIL repeat_events: got %0d events want 3", got.size());
        end else foreach (exp[i]) begin
            n_checks++;
            if (got[i] !== exp[i]) begin
                n_fail++; $display("FAIL repeat_event%0d: got %h want %h", i, got[i], exp[i]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] b[9] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
        do_reset();
        foreach (b[i]) send(b[i]);
        n_checks++;
        if (fifo_count !== 4'd8 || overflow !== 1'b1 || evt_data !== 16'h0015) begin
            n_fail++;
            $display("FAIL overflow_full: got count=%0d ovf=%b head=%h want 8 1 0015",
                     fifo_count, overflow, evt_data);
        end
        tick(0, 8'h00, 0, 1);
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++; $display("FAIL overflow_clr: got %b want 0", overflow);
        end
        tick(1, 8'h4D, 1, 0);
        n_checks++;
        if (fifo_count !== 4'd8 || overflow !== 1'b0 || evt_data !== 16'h001D) begin
            n_fail++;
            $display("FAIL full_push_pop: got count=%0d ovf=%b head=%h want 8 0 001D",
                     fifo_count, overflow, evt_data);
        end
        drain();
        n_checks++;
        if (got.size() != 8 || got[7] !== 16'h004D) begin
            n_fail++; $display("FAIL full_push_pop_tail: got %0d events want 8 ending 004D", got.size());
        end
    endtask

    task automatic test_reset_mid_seq();
        do_reset();
        send(8'hE0);
        reset = 1;
        tick(1, 8'h12, 0, 0);
        n_checks++;
        if ({evt_valid, evt_data, fifo_count, overflow, shift_held} !== 23'd0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got v=%b d=%h c=%0d o=%b s=%b want all 0",
                     evt_valid, evt_data, fifo_count, overflow, shift_held);
        end
        reset = 0;
        send(8'h1C);
        drain();
        n_checks++;
        if (got.size() != 1 || got[0] !== 16'h001C) begin
            n_fail++; $display("FAIL reset_mid_event: got %0d events head %h want 1 001C",
                               got.size(), got.size() ? got[0] : 16'hxxxx);
        end
    endtask

    task automatic test_error_codes();
        logic [7:0] b[5] = '{8'hF0, 8'hE0, 8'h6B, 8'h00, 8'h1C};
        do_reset();
        foreach (b[i]) send(b[i]);
        drain();
        n_checks++;
        if (got.size() != 2 || got[0] !== 16'h406B || got[1] !== 16'h001C) begin
            n_fail++; $display("FAIL error_codes: got %0d events want 406B,001C", got.size());
        end
    endtask

    task automatic test_random();
        logic [7:0] pool[10] = '{8'h12, 8'h59, 8'h1C, 8'h75, 8'h6B, 8'hE0, 8'hF0, 8'h00, 8'hFF, 8'h1C};
        logic [7:0] c;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            c = ($urandom_range(0, 3) == 0) ? 8'($urandom) : pool[$urandom_range(0, 9)];
            tick($urandom_range(0, 9) < 7, c, $urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0);
            n_checks++;
            if (evt_valid !== (m_q.size() > 0) || fifo_count !== 4'(m_q.size()) ||
                overflow !== m_ovf || shift_held !== (m_l | m_r) ||
                (m_q.size() > 0 && evt_data !== m_q[0])) begin
                n_fail++;
                $display("FAIL random_cycle%0d: got v=%b c=%0d o=%b s=%b d=%h want v=%b c=%0d o=%b s=%b d=%h",
                         i, evt_valid, fifo_count, overflow, shift_held, evt_data,
                         m_q.size() > 0, m_q.size(), m_ovf, m_l | m_r,
                         m_q.size() > 0 ? m_q[0] : 16'h0000);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_prefixes();
        test_shift();
        test_repeat();
        test_overflow();
        test_reset_mid_seq();
        test_error_codes();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
